// File: rtl/mem_unit.sv
// Data-memory responder for the load/store reservation stations: one request at a time,
// fixed per-operation latency, completion held until the requester withdraws.
module mem_unit #(
    parameter int ADDR_BITS  = 5,
    parameter int LD_LATENCY = 3,
    parameter int ST_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  control,
    input  logic [63:0] mem_address,
    input  logic [63:0] mem_data,
    input  logic [3:0]  mem_tag,
    output logic        mem_ready,
    output logic [63:0] ld_data,
    output logic [3:0]  done_tag,
    output logic        done_is_ld,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [3:0]             tag_r;
    logic                   is_ld_r;
    logic [ADDR_BITS-1:0]   idx_r;
    logic [63:0]            data_r;
    logic [63:0]            mem_r [DEPTH];

    logic                   is_req_s;
    logic                   withdraw_s;
    logic [ADDR_BITS-1:0]   idx_s;
    logic                   unused_addr_s;

    // Request decode; control[1] set means idle (both 2'b11 and 2'b10).
    assign is_req_s      = (control == 2'b01) || (control == 2'b00);
    assign withdraw_s    = control[1] || (mem_tag != tag_r);
    assign idx_s         = mem_address[ADDR_BITS+2:3];
    assign unused_addr_s = ^{mem_address[63:ADDR_BITS+3], mem_address[2:0]};

    // Request FSM, memory array and registered completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            tag_r      <= 4'd0;
            is_ld_r    <= 1'b0;
            idx_r      <= {ADDR_BITS{1'b0}};
            data_r     <= 64'd0;
            mem_ready  <= 1'b0;
            ld_data    <= 64'd0;
            done_tag   <= 4'd0;
            done_is_ld <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 64'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (is_req_s) begin
                        tag_r   <= mem_tag;
                        is_ld_r <= control[0];
                        idx_r   <= idx_s;
                        data_r  <= mem_data;
                        cnt_r   <= control[0] ? CNT_W'(LD_LATENCY - 1)
                                              : CNT_W'(ST_LATENCY - 1);
                        busy    <= 1'b1;
                        state_r <= ST_BUSY;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // An abort on the final counting edge still suppresses the store.
                    if (withdraw_s) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r == {CNT_W{1'b0}}) begin
                        if (is_ld_r) begin
                            ld_data <= mem_r[idx_r];
                        end else begin
                            mem_r[idx_r] <= data_r;
                        end
                        mem_ready  <= 1'b1;
                        done_tag   <= tag_r;
                        done_is_ld <= is_ld_r;
                        state_r    <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (withdraw_s) begin
                        mem_ready  <= 1'b0;
                        done_tag   <= 4'd0;
                        done_is_ld <= 1'b0;
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        mem_ready  <= 1'b1;
                    end
                end
                default: begin
                    mem_ready  <= 1'b0;
                    done_tag   <= 4'd0;
                    done_is_ld <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// Directed self-checking bench for mem_unit: latency, hold/release, abort, wrap and reset.
module tb_mem_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  control;
    logic [63:0] mem_address;
    logic [63:0] mem_data;
    logic [3:0]  mem_tag;
    logic        mem_ready;
    logic [63:0] ld_data;
    logic [3:0]  done_tag;
    logic        done_is_ld;
    logic        busy;

    int total;
    int bad;

    mem_unit #(.ADDR_BITS(5), .LD_LATENCY(3), .ST_LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .control    (control),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_tag    (mem_tag),
        .mem_ready  (mem_ready),
        .ld_data    (ld_data),
        .done_tag   (done_tag),
        .done_is_ld (done_is_ld),
        .busy       (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a request and measure edges from acceptance until mem_ready.
    task automatic req(input logic [1:0] ctl, input logic [63:0] addr, input logic [63:0] data,
                       input logic [3:0] tag, input int exp_lat);
        int n;
        bit seen;
        @(negedge clk);
        control     = ctl;
        mem_address = addr;
        mem_data    = data;
        mem_tag     = tag;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_ready) seen = 1'b1;
        end
        chk("latency", 64'(n - 1), 64'(exp_lat));
        chk("busy_done", {63'd0, busy}, 64'd1);
    endtask

    task automatic release_req();
        @(negedge clk);
        control = 2'b11;
        @(posedge clk);
        #1;
        chk("rel_ready", {63'd0, mem_ready}, 64'd0);
        chk("rel_busy", {63'd0, busy}, 64'd0);
        chk("rel_tag", {60'd0, done_tag}, 64'd0);
        chk("rel_is_ld", {63'd0, done_is_ld}, 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        control     = 2'b11;
        mem_address = 64'd0;
        mem_data    = 64'd0;
        mem_tag     = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {63'd0, mem_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ld_data", ld_data, 64'd0);
        chk("rst_tag", {60'd0, done_tag}, 64'd0);

        // Dirty address 0x18, then an asynchronous mid-cycle reset must clear it.
        req(2'b00, 64'h18, 64'h1234, 4'd9, 2);
        release_req();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        req(2'b01, 64'h18, 64'd0, 4'd6, 3);
        chk("t1_ld_data", ld_data, 64'd0);
        chk("t1_tag", {60'd0, done_tag}, 64'd6);
        chk("t1_is_ld", {63'd0, done_is_ld}, 64'd1);
        release_req();

        // Store then load the same word.
        req(2'b00, 64'h40, 64'hDEADBEEF_00000001, 4'd9, 2);
        chk("t2_st_tag", {60'd0, done_tag}, 64'd9);
        chk("t2_st_is_ld", {63'd0, done_is_ld}, 64'd0);
        release_req();
        req(2'b01, 64'h40, 64'd0, 4'd7, 3);
        chk("t2_ld_data", ld_data, 64'hDEADBEEF_00000001);
        chk("t2_ld_tag", {60'd0, done_tag}, 64'd7);
        release_req();

        // Hold a completed load for five cycles, then release.
        req(2'b01, 64'h40, 64'd0, 4'd8, 3);
        held = ld_data;
        chk("t3_ld_data", held, 64'hDEADBEEF_00000001);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t3_hold", {63'd0, mem_ready}, 64'd1);
        end
        release_req();
        chk("t3_ld_kept", ld_data, 64'hDEADBEEF_00000001);

        // Abort a store by changing the tag one cycle after acceptance.
        @(negedge clk);
        control     = 2'b00;
        mem_address = 64'h08;
        mem_data    = 64'h55;
        mem_tag     = 4'd10;
        @(posedge clk);
        #1;
        chk("t4_accept", {63'd0, busy}, 64'd1);
        @(negedge clk);
        mem_tag = 4'd9;
        @(posedge clk);
        #1;
        chk("t4_abort_busy", {63'd0, busy}, 64'd0);
        chk("t4_abort_ready", {63'd0, mem_ready}, 64'd0);
        @(negedge clk);
        control = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("t4_no_ready", {63'd0, mem_ready}, 64'd0);
        end
        req(2'b01, 64'h08, 64'd0, 4'd6, 3);
        chk("t4_ld_data", ld_data, 64'd0);
        release_req();

        // Address wrap and ignored byte offset: 0x100 and 0x005 both hit word 0.
        req(2'b00, 64'h100, 64'hAA, 4'd10, 2);
        release_req();
        req(2'b01, 64'h005, 64'd0, 4'd6, 3);
        chk("t5_ld_data", ld_data, 64'hAA);
        release_req();

        // Reset during BUSY abandons the store.
        @(negedge clk);
        control     = 2'b00;
        mem_address = 64'h10;
        mem_data    = 64'h77;
        mem_tag     = 4'd9;
        @(posedge clk);
        #1;
        chk("t6_busy", {63'd0, busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_ready", {63'd0, mem_ready}, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        control = 2'b11;
        req(2'b01, 64'h10, 64'd0, 4'd7, 3);
        chk("t6_ld_data", ld_data, 64'd0);
        release_req();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
